// File: rtl/ssd_scan_ctrl_if.sv
// Bus between the scan controller and the shared combinational SSD datapath.
// The controller presents operands/opcode/enable and receives segments a..g.
interface ssd_scan_ctrl_if #(
  parameter int N = 4
);
  logic [N-1:0] ssd_a;
  logic [N-1:0] ssd_b;
  logic [1:0]   ssd_op;
  logic         ssd_en;
  logic [6:0]   seg_in;

  modport master (
    output ssd_a, ssd_b, ssd_op, ssd_en,
    input  seg_in
  );

  modport slave (
    input  ssd_a, ssd_b, ssd_op, ssd_en,
    output seg_in
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller: time-multiplexes one SSD datapath
// over four host-written slots and drives one active-low anode at a time.
module ssd_scan_ctrl #(
  parameter int N     = 4,
  parameter int DWELL = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            wr_en,
  input  logic            clr_en,
  input  logic [1:0]      wr_slot,
  input  logic [N-1:0]    wr_a,
  input  logic [N-1:0]    wr_b,
  input  logic [1:0]      wr_op,
  ssd_scan_ctrl_if.master ssd,
  output logic [6:0]      seg_out,
  output logic [3:0]      an,
  output logic            frame_done
);

  typedef enum logic [1:0] {S_OFF, S_DRIVE, S_LATCH, S_DWELL} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  logic [3:0]   slot_valid;
  logic [N-1:0] slot_a  [4];
  logic [N-1:0] slot_b  [4];
  logic [1:0]   slot_op [4];

  // Write beats clear on the same slot, so a collision leaves the slot valid.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic         valid_reg;
      logic [N-1:0] a_reg;
      logic [N-1:0] b_reg;
      logic [1:0]   op_reg;
      logic         hit;

      assign hit = (wr_slot == 2'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          a_reg     <= '0;
          b_reg     <= '0;
          op_reg    <= '0;
        end else if (wr_en && hit) begin
          valid_reg <= 1'b1;
          a_reg     <= wr_a;
          b_reg     <= wr_b;
          op_reg    <= wr_op;
        end else if (clr_en && hit) begin
          valid_reg <= 1'b0;
        end
      end

      assign slot_valid[gi] = valid_reg;
      assign slot_a[gi]     = a_reg;
      assign slot_b[gi]     = b_reg;
      assign slot_op[gi]    = op_reg;
    end
  endgenerate

  state_t       state_reg, state_next;
  logic [1:0]   idx_reg, idx_next;
  logic [15:0]  cnt_reg, cnt_next;
  logic [3:0]   an_reg, an_next;
  logic [6:0]   seg_out_reg, seg_out_next;
  logic         frame_done_reg, frame_done_next;
  logic [N-1:0] ssd_a_reg, ssd_a_next;
  logic [N-1:0] ssd_b_reg, ssd_b_next;
  logic [1:0]   ssd_op_reg, ssd_op_next;
  logic         ssd_en_reg, ssd_en_next;

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    seg_out_next    = seg_out_reg;
    ssd_a_next      = ssd_a_reg;
    ssd_b_next      = ssd_b_reg;
    ssd_op_next     = ssd_op_reg;
    ssd_en_next     = ssd_en_reg;

    case (state_reg)
      S_OFF: begin
        if (run) begin
          state_next = S_DRIVE;
          idx_next   = 2'd0;
        end
      end
      S_DRIVE: begin
        state_next  = S_LATCH;
        ssd_a_next  = slot_a[idx_reg];
        ssd_b_next  = slot_b[idx_reg];
        ssd_op_next = slot_op[idx_reg];
        ssd_en_next = slot_valid[idx_reg];
      end
      S_LATCH: begin
        state_next   = S_DWELL;
        cnt_next     = '0;
        seg_out_next = ssd.seg_in;
      end
      S_DWELL: begin
        if (cnt_reg == DWELL_LAST) begin
          state_next = S_DRIVE;
          idx_next   = idx_reg + 2'd1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = S_OFF;
    endcase

    // Dropping run blanks the display from any state and rewinds to slot 0.
    if (!run) begin
      state_next   = S_OFF;
      idx_next     = 2'd0;
      cnt_next     = '0;
      seg_out_next = '0;
      ssd_en_next  = 1'b0;
    end

    an_next = 4'hF;
    if (state_next == S_DWELL) begin
      an_next = ~(4'b0001 << idx_next);
    end
    frame_done_next = (state_next == S_DWELL) && (idx_next == 2'd3) &&
                      (cnt_next == DWELL_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_OFF;
      idx_reg        <= 2'd0;
      cnt_reg        <= '0;
      an_reg         <= 4'hF;
      seg_out_reg    <= '0;
      frame_done_reg <= 1'b0;
      ssd_a_reg      <= '0;
      ssd_b_reg      <= '0;
      ssd_op_reg     <= '0;
      ssd_en_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      an_reg         <= an_next;
      seg_out_reg    <= seg_out_next;
      frame_done_reg <= frame_done_next;
      ssd_a_reg      <= ssd_a_next;
      ssd_b_reg      <= ssd_b_next;
      ssd_op_reg     <= ssd_op_next;
      ssd_en_reg     <= ssd_en_next;
    end
  end

  assign ssd.ssd_a  = ssd_a_reg;
  assign ssd.ssd_b  = ssd_b_reg;
  assign ssd.ssd_op = ssd_op_reg;
  assign ssd.ssd_en = ssd_en_reg;
  assign seg_out    = seg_out_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl with a behavioural SSD datapath;
// expected digits are queued when stimulus is applied and popped per lit digit.
module tb_ssd_scan_ctrl;
  localparam int N     = 4;
  localparam int DWELL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run = 1'b0;
  logic         wr_en = 1'b0;
  logic         clr_en = 1'b0;
  logic [1:0]   wr_slot = '0;
  logic [1:0]   wr_op = '0;
  logic [N-1:0] wr_a = '0;
  logic [N-1:0] wr_b = '0;
  logic [6:0]   seg_out;
  logic [3:0]   an;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       en;
  } exp_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       en;
    int         len;
    int         gap;
    int         fd_cnt;
    int         fd_pos;
    bit         stable;
    bit         ok;
  } digit_t;

  exp_t exp_q[$];

  ssd_scan_ctrl_if #(.N(N)) ssd ();

  ssd_scan_ctrl #(.N(N), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .wr_en     (wr_en),
    .clr_en    (clr_en),
    .wr_slot   (wr_slot),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .wr_op     (wr_op),
    .ssd       (ssd),
    .seg_out   (seg_out),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural SSD datapath: 4-bit ALU result shown as a hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1111110;  4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;  4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;  4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;  4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;  4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;  default: hex7 = 7'b1000111;
    endcase
  endfunction

  logic [3:0] ssd_res;
  always_comb begin
    ssd_res = '0;
    case (ssd.ssd_op)
      2'd0: ssd_res = ssd.ssd_a + ssd.ssd_b;
      2'd1: ssd_res = ssd.ssd_a | ssd.ssd_b;
      2'd2: ssd_res = ssd.ssd_a - ssd.ssd_b;
      default: ssd_res = ssd.ssd_a ^ ssd.ssd_b;
    endcase
  end
  assign ssd.seg_in = ssd.ssd_en ? hex7(ssd_res) : 7'd0;

  int cyc = 0;
  int fd_last_cyc = -1;
  int fd_period = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (frame_done === 1'b1) begin
      if (fd_last_cyc >= 0) fd_period = cyc - fd_last_cyc;
      fd_last_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic write_slot(input logic [1:0] s, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [1:0] op, input logic wr, input logic clr);
    wr_slot = s; wr_a = a; wr_b = b; wr_op = op; wr_en = wr; clr_en = clr;
    @(negedge clk);
    wr_en = 1'b0; clr_en = 1'b0;
  endtask

  // Waits for the next lit digit (sampled on falling edges) and measures it.
  task automatic next_digit(output digit_t d);
    int guard;
    guard = 0;
    d.an = 4'hF; d.seg = '0; d.en = 1'b0; d.len = 0; d.gap = 0;
    d.fd_cnt = 0; d.fd_pos = 0; d.stable = 1'b1; d.ok = 1'b1;
    while (an === 4'hF) begin
      if (frame_done === 1'b1) d.fd_cnt++;
      d.gap++; guard++;
      if (guard > 200) begin d.ok = 1'b0; return; end
      @(negedge clk);
    end
    d.an = an; d.seg = seg_out; d.en = ssd.ssd_en;
    while (an === d.an) begin
      d.len++; guard++;
      if (seg_out !== d.seg) d.stable = 1'b0;
      if (frame_done === 1'b1) begin d.fd_cnt++; d.fd_pos = d.len; end
      if (guard > 200) begin d.ok = 1'b0; return; end
      @(negedge clk);
    end
    $display("digit an=%b seg=%b en=%b len=%0d gap=%0d fd=%0d", d.an, d.seg, d.en, d.len, d.gap, d.fd_cnt);
  endtask

  task automatic test_reset();
    int lit, pulses;
    rst_n = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
    checks++; if (seg_out !== 7'd0) begin errors++; $display("FAIL reset_seg got %b want 0000000", seg_out); end
    checks++; if ({ssd.ssd_a, ssd.ssd_b, ssd.ssd_op, ssd.ssd_en} !== '0) begin
      errors++; $display("FAIL reset_ssd got %h/%h/%h/%b want 0/0/0/0", ssd.ssd_a, ssd.ssd_b, ssd.ssd_op, ssd.ssd_en);
    end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
    rst_n = 1'b1;
    lit = 0; pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (an !== 4'hF || seg_out !== 7'd0) lit++;
      if (frame_done !== 1'b0) pulses++;
    end
    checks++; if (lit != 0) begin errors++; $display("FAIL idle_dark got %0d lit cycles want 0", lit); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL idle_fd got %0d pulses want 0", pulses); end
  endtask

  task automatic test_basic_scan();
    digit_t d;
    exp_t   e;
    write_slot(2'd0, 4'd10, 4'd10, 2'd2, 1'b1, 1'b0);
    write_slot(2'd1, 4'd1,  4'd2,  2'd0, 1'b1, 1'b0);
    write_slot(2'd2, 4'd10, 4'd8,  2'd3, 1'b1, 1'b0);
    write_slot(2'd3, 4'd15, 4'd7,  2'd3, 1'b1, 1'b0);
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back('{4'b1110, 7'b1111110, 1'b1});
      exp_q.push_back('{4'b1101, 7'b1111001, 1'b1});
      exp_q.push_back('{4'b1011, 7'b1101101, 1'b1});
      exp_q.push_back('{4'b0111, 7'b1111111, 1'b1});
    end
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_digit(d);
      e = exp_q.pop_front();
      checks++; if ({d.an, d.seg, d.en} !== e) begin
        errors++; $display("FAIL basic_digit[%0d] got %b want %b", i, {d.an, d.seg, d.en}, e);
      end
      checks++; if (d.len != DWELL || !d.stable) begin
        errors++; $display("FAIL basic_len[%0d] got %0d stable=%0b want %0d stable=1", i, d.len, d.stable, DWELL);
      end
      checks++; if (d.gap != ((i == 0) ? 3 : 2)) begin
        errors++; $display("FAIL basic_gap[%0d] got %0d want %0d", i, d.gap, (i == 0) ? 3 : 2);
      end
      checks++; if (d.fd_cnt != ((e.an == 4'b0111) ? 1 : 0) || (e.an == 4'b0111 && d.fd_pos != DWELL)) begin
        errors++; $display("FAIL basic_fd[%0d] got cnt=%0d pos=%0d want cnt=%0d pos=%0d", i, d.fd_cnt, d.fd_pos,
                           (e.an == 4'b0111) ? 1 : 0, (e.an == 4'b0111) ? DWELL : 0);
      end
    end
    checks++; if (fd_period != 4 * (DWELL + 2)) begin
      errors++; $display("FAIL frame_period got %0d want %0d", fd_period, 4 * (DWELL + 2));
    end
  endtask

  task automatic test_invalid_slot();
    digit_t d;
    exp_t   e;
    write_slot(2'd2, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1);
    exp_q.push_back('{4'b1110, 7'b1111110, 1'b1});
    exp_q.push_back('{4'b1101, 7'b1111001, 1'b1});
    exp_q.push_back('{4'b1011, 7'b0000000, 1'b0});
    exp_q.push_back('{4'b0111, 7'b1111111, 1'b1});
    for (int i = 0; i < 4; i++) begin
      next_digit(d);
      e = exp_q.pop_front();
      checks++; if ({d.an, d.seg, d.en} !== e || d.len != DWELL) begin
        errors++; $display("FAIL invalid_digit[%0d] got %b len %0d want %b len %0d", i, {d.an, d.seg, d.en}, d.len, e, DWELL);
      end
    end
  endtask

  task automatic test_live_rewrite();
    digit_t d;
    exp_t   e;
    int     guard;
    bit     stable;
    guard = 0;
    while (an !== 4'b1101 && guard < 200) begin guard++; @(negedge clk); end
    checks++; if (an !== 4'b1101 || seg_out !== 7'b1111001) begin
      errors++; $display("FAIL live_before got an=%b seg=%b want an=1101 seg=1111001", an, seg_out);
    end
    write_slot(2'd1, 4'd4, 4'd5, 2'd0, 1'b1, 1'b0);
    stable = 1'b1; guard = 0;
    while (an === 4'b1101 && guard < 200) begin
      if (seg_out !== 7'b1111001) stable = 1'b0;
      guard++;
      @(negedge clk);
    end
    checks++; if (!stable) begin errors++; $display("FAIL live_hold got changed segments want 1111001 held"); end
    exp_q.push_back('{4'b1011, 7'b0000000, 1'b0});
    exp_q.push_back('{4'b0111, 7'b1111111, 1'b1});
    exp_q.push_back('{4'b1110, 7'b1111110, 1'b1});
    exp_q.push_back('{4'b1101, 7'b1111011, 1'b1});
    for (int i = 0; i < 4; i++) begin
      next_digit(d);
      e = exp_q.pop_front();
      checks++; if ({d.an, d.seg, d.en} !== e) begin
        errors++; $display("FAIL live_digit[%0d] got %b want %b", i, {d.an, d.seg, d.en}, e);
      end
    end
  endtask

  task automatic test_collision();
    digit_t d;
    exp_t   e;
    write_slot(2'd0, 4'd5, 4'd5, 2'd0, 1'b1, 1'b1);
    exp_q.push_back('{4'b1011, 7'b0000000, 1'b0});
    exp_q.push_back('{4'b0111, 7'b1111111, 1'b1});
    exp_q.push_back('{4'b1110, 7'b1110111, 1'b1});
    exp_q.push_back('{4'b1101, 7'b1111011, 1'b1});
    for (int i = 0; i < 4; i++) begin
      next_digit(d);
      e = exp_q.pop_front();
      checks++; if ({d.an, d.seg, d.en} !== e) begin
        errors++; $display("FAIL collision_digit[%0d] got %b want %b", i, {d.an, d.seg, d.en}, e);
      end
    end
  endtask

  task automatic test_run_drop();
    digit_t d;
    exp_t   e;
    int     guard, lit;
    guard = 0;
    while (an !== 4'b1011 && guard < 200) begin guard++; @(negedge clk); end
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    checks++; if (an !== 4'hF || seg_out !== 7'd0 || ssd.ssd_en !== 1'b0) begin
      errors++; $display("FAIL drop_off got an=%b seg=%b en=%b want an=1111 seg=0000000 en=0", an, seg_out, ssd.ssd_en);
    end
    lit = 0;
    repeat (5) begin
      @(negedge clk);
      if (an !== 4'hF || frame_done !== 1'b0) lit++;
    end
    checks++; if (lit != 0) begin errors++; $display("FAIL drop_dark got %0d active cycles want 0", lit); end
    exp_q.push_back('{4'b1110, 7'b1110111, 1'b1});
    run = 1'b1;
    next_digit(d);
    e = exp_q.pop_front();
    checks++; if ({d.an, d.seg, d.en} !== e || d.gap != 3) begin
      errors++; $display("FAIL restart_digit got %b gap %0d want %b gap 3", {d.an, d.seg, d.en}, d.gap, e);
    end
  endtask

  task automatic test_reset_mid();
    digit_t d;
    exp_t   e;
    int     guard;
    guard = 0;
    while (an !== 4'b1101 && guard < 200) begin guard++; @(negedge clk); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (an !== 4'hF || seg_out !== 7'd0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midreset_out got an=%b seg=%b fd=%b want 1111/0000000/0", an, seg_out, frame_done);
    end
    checks++; if ({ssd.ssd_a, ssd.ssd_b, ssd.ssd_op, ssd.ssd_en} !== '0) begin
      errors++; $display("FAIL midreset_ssd got %h/%h/%h/%b want 0/0/0/0", ssd.ssd_a, ssd.ssd_b, ssd.ssd_op, ssd.ssd_en);
    end
    exp_q.push_back('{4'b1110, 7'b0000000, 1'b0});
    exp_q.push_back('{4'b1101, 7'b0000000, 1'b0});
    exp_q.push_back('{4'b1011, 7'b0000000, 1'b0});
    exp_q.push_back('{4'b0111, 7'b0000000, 1'b0});
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_digit(d);
      e = exp_q.pop_front();
      checks++; if ({d.an, d.seg, d.en} !== e || d.len != DWELL) begin
        errors++; $display("FAIL blank_digit[%0d] got %b len %0d want %b len %0d", i, {d.an, d.seg, d.en}, d.len, e, DWELL);
      end
      if (i == 0) begin
        checks++; if (d.gap != 3) begin errors++; $display("FAIL blank_gap got %0d want 3", d.gap); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_invalid_slot();
    test_live_rewrite();
    test_collision();
    test_run_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
